input_holder: RTL and testbench
===============================

INPUT_HOLDER -- requirements
Module: input_holder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of strobe synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 8'd255, the number of stable cycles required by the debounce filter; it is used only when INPUT_HOLDER_DEBOUNCE_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the system clock, rising-edge active.
REQ-004 SHALL have port nrst, input, 1 bit: the reset, asynchronous, active-low.
REQ-005 SHALL have port data_in, input, 8 bits: the user byte from the chip pins, asynchronous, and required stable while load_strobe is high.
REQ-006 SHALL have port load_strobe, input, 1 bit: the user "byte valid" pin, asynchronous, level-held by the user.
REQ-007 SHALL have port interface_state, input, interface_state_t: the state from the interface FSM.
REQ-008 SHALL have port cipher_ready, input, 1 bit: the encryption block can accept a byte this cycle.
REQ-009 SHALL have port data_out, output, 8 bits: the captured byte sent to the encryption block.
REQ-010 SHALL have port data_out_pulse, output, 1 bit: a single-cycle valid strobe to the encryption block.
REQ-011 SHALL have port input_holder_state_out, output, input_holder_state_t: the current state, sent to the interface FSM.
REQ-012 SHALL have port overrun, output, 1 bit: a sticky flag meaning a strobe edge arrived while a byte was still pending.

Function
REQ-013 SHALL pass load_strobe through SYNC_STAGES flops and then the optional debounce filter; the result is strb_f, and strb_f_d is strb_f delayed by one cycle.
REQ-014 SHALL define a rising edge as strb_f=1 and strb_f_d=0.
REQ-015 SHALL implement states H_EMPTY, H_PENDING and H_SENT.
REQ-016 H_EMPTY: on a rising edge, SHALL latch data_in into the holding register and move to H_PENDING at that clock edge.
REQ-017 H_PENDING: when cipher_ready=1 is sampled, SHALL register data_out_pulse=1 for exactly one cycle and move to H_SENT; otherwise SHALL stay in H_PENDING indefinitely.
REQ-018 H_PENDING: a rising edge SHALL NOT overwrite the holding register, and SHALL set overrun.
REQ-019 H_SENT: SHALL move to H_EMPTY when strb_f=0; a held strobe SHALL never produce a second byte.
REQ-020 data_out SHALL equal the holding register at all times, and SHALL remain unchanged until the next capture.
REQ-021 When interface_state==I_IDLE, SHALL force the next state to H_EMPTY, clear overrun, suppress capture and data_out_pulse, and retain data_out.
REQ-022 I_IDLE SHALL have priority over every simultaneous event, including cipher_ready in H_PENDING and a rising edge in H_EMPTY.
REQ-023 The minimum latency from a pin rising edge to data_out_pulse SHALL be SYNC_STAGES+2 cycles with no debounce and cipher_ready=1.
REQ-024 data_out_pulse SHALL never be high on two consecutive cycles.

Reset
REQ-025 nrst low SHALL asynchronously set: state H_EMPTY, holding register 8'h00, data_out_pulse 0, overrun 0, all synchronizer and debounce flops 0.
REQ-026 Reset mid-operation SHALL discard any pending byte; no data_out_pulse SHALL be emitted for it after release.

Configuration
REQ-027 With INPUT_HOLDER_DEBOUNCE_EN defined, strb_f SHALL change only after the synchronized strobe has held its new level for DEBOUNCE_CYCLES consecutive cycles, using an 8-bit counter that restarts on any mismatch.
REQ-028 With INPUT_HOLDER_DEBOUNCE_EN undefined, strb_f SHALL equal the synchronizer output, and no counter logic SHALL exist.

Structure
REQ-029 input_holder_state_t (H_EMPTY=0, H_PENDING, H_SENT) SHALL be added to types_pkg, next to interface_state_t.
REQ-030 The synchronizer and debounce logic SHALL be one sub-module, strobe_conditioner (parameters SYNC_STAGES and DEBOUNCE_CYCLES), instantiated once.

Verification
REQ-031 Bench SHALL cover: data_in=8'hA5, strobe held high 10 cycles, cipher_ready=1, no debounce -> one pulse, data_out=8'hA5, state returns to H_EMPTY after the strobe falls.
REQ-032 Bench SHALL cover: capture 8'h3C with cipher_ready=0 for 20 cycles, then 1 -> no pulse for 20 cycles, then one pulse with data_out=8'h3C.
REQ-033 Bench SHALL cover: in H_PENDING with 8'h11, strobe low then high with data_in=8'h22 -> overrun=1, data_out stays 8'h11; a subsequent I_IDLE clears overrun.
REQ-034 Bench SHALL cover: interface_state=I_IDLE in the same cycle as cipher_ready=1 in H_PENDING -> no pulse, state H_EMPTY.
REQ-035 Bench SHALL cover: nrst asserted in H_PENDING (data 8'hFF) -> data_out=8'h00, and no pulse after release.
REQ-036 Bench SHALL cover, with DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 3-cycle strobe glitch -> no capture; a 4-cycle stable high -> capture.

Source files
------------

// File: rtl/types_pkg.sv
// Shared state types for the interface FSM and the input holder.
package types_pkg;

    typedef enum logic [1:0] {
        I_IDLE   = 2'd0,
        I_ACTIVE = 2'd1,
        I_BUSY   = 2'd2
    } interface_state_t;

    typedef enum logic [1:0] {
        H_EMPTY   = 2'd0,
        H_PENDING = 2'd1,
        H_SENT    = 2'd2
    } input_holder_state_t;

endpackage

// File: rtl/strobe_conditioner.sv
// Synchronises the async load strobe, then optionally debounces it (INPUT_HOLDER_DEBOUNCE_EN).
// Latency SYNC_STAGES cycles, plus DEBOUNCE_CYCLES when debounced; no backpressure.
module strobe_conditioner #(
    parameter int       SYNC_STAGES     = 2,
    parameter bit [7:0] DEBOUNCE_CYCLES = 8'd255
) (
    input  logic clk,
    input  logic nrst,
    input  logic strb_async,
    output logic strb_f
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strb_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strb_async};
        end
    end

    assign strb_sync = sync_q[SYNC_STAGES-1];

`ifdef INPUT_HOLDER_DEBOUNCE_EN
    logic [7:0] stable_cnt;
    logic       strb_filt;

    // Counter runs only while the synced level disagrees with the filtered one.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stable_cnt <= 8'd0;
            strb_filt  <= 1'b0;
        end else if (strb_sync == strb_filt) begin
            stable_cnt <= 8'd0;
        end else if (stable_cnt == DEBOUNCE_CYCLES - 8'd1) begin
            stable_cnt <= 8'd0;
            strb_filt  <= strb_sync;
        end else begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

    assign strb_f = strb_filt;
`else
    wire unused_debounce_cfg = ^DEBOUNCE_CYCLES;

    assign strb_f = strb_sync;
`endif

endmodule

// File: rtl/input_holder.sv
// Captures one user byte per strobe and hands it to the cipher; debounce via INPUT_HOLDER_DEBOUNCE_EN.
// Pin-to-pulse latency SYNC_STAGES+2 min; holds the byte while cipher_ready is low, flags overrun.
module input_holder
    import types_pkg::*;
#(
    parameter int       SYNC_STAGES     = 2,
    parameter bit [7:0] DEBOUNCE_CYCLES = 8'd255
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [7:0]          data_in,
    input  logic                load_strobe,
    input  interface_state_t    interface_state,
    input  logic                cipher_ready,
    output logic [7:0]          data_out,
    output logic                data_out_pulse,
    output input_holder_state_t input_holder_state_out,
    output logic                overrun
);

    logic                strb_f;
    logic                strb_f_d;
    logic                strb_rise;

    input_holder_state_t state_q, state_nxt;
    logic [7:0]          hold_q, hold_nxt;
    logic                pulse_q, pulse_nxt;
    logic                ovr_q, ovr_nxt;

    strobe_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_strobe_conditioner (
        .clk        (clk),
        .nrst       (nrst),
        .strb_async (load_strobe),
        .strb_f     (strb_f)
    );

    assign strb_rise = strb_f & ~strb_f_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            strb_f_d <= 1'b0;
            state_q  <= H_EMPTY;
            hold_q   <= 8'h00;
            pulse_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            strb_f_d <= strb_f;
            state_q  <= state_nxt;
            hold_q   <= hold_nxt;
            pulse_q  <= pulse_nxt;
            ovr_q    <= ovr_nxt;
        end
    end

    // I_IDLE overrides everything but leaves the last captured byte visible.
    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        pulse_nxt = 1'b0;
        ovr_nxt   = ovr_q;
        if (interface_state == I_IDLE) begin
            state_nxt = H_EMPTY;
            ovr_nxt   = 1'b0;
        end else begin
            unique case (state_q)
                H_EMPTY: begin
                    if (strb_rise) begin
                        hold_nxt  = data_in;
                        state_nxt = H_PENDING;
                    end
                end
                H_PENDING: begin
                    if (strb_rise) begin
                        ovr_nxt = 1'b1;
                    end
                    if (cipher_ready) begin
                        pulse_nxt = 1'b1;
                        state_nxt = H_SENT;
                    end
                end
                H_SENT: begin
                    if (!strb_f) begin
                        state_nxt = H_EMPTY;
                    end
                end
                default: state_nxt = H_EMPTY;
            endcase
        end
    end

    assign data_out               = hold_q;
    assign data_out_pulse         = pulse_q;
    assign input_holder_state_out = state_q;
    assign overrun                = ovr_q;

endmodule

// File: tb/tb_input_holder.sv
// Directed and random checks of input_holder against a behavioural byte-handoff model.
module tb_input_holder;
    import types_pkg::*;

    localparam int SYNC = 2;
`ifdef INPUT_HOLDER_DEBOUNCE_EN
    localparam bit [7:0] DEB = 8'd4;
`else
    localparam bit [7:0] DEB = 8'd255;
`endif

    logic                clk = 1'b0;
    logic                nrst;
    logic [7:0]          data_in;
    logic                load_strobe;
    interface_state_t    interface_state;
    logic                cipher_ready;
    logic [7:0]          data_out;
    logic                data_out_pulse;
    input_holder_state_t input_holder_state_out;
    logic                overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    // Model: pin history, byte held for the cipher, byte delivered awaiting strobe release.
    bit       pin_hist [0:7];
    bit       m_held, m_latched, m_ovr, m_pulse;
    bit [7:0] m_data;

    input_holder #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk                    (clk),
        .nrst                   (nrst),
        .data_in                (data_in),
        .load_strobe            (load_strobe),
        .interface_state        (interface_state),
        .cipher_ready           (cipher_ready),
        .data_out               (data_out),
        .data_out_pulse         (data_out_pulse),
        .input_holder_state_out (input_holder_state_out),
        .overrun                (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) pin_hist[i] = 1'b0;
        m_held = 0; m_latched = 0; m_ovr = 0; m_pulse = 0; m_data = 8'h00;
    endtask

    // Strobe seen at edge k is the pin sampled SYNC edges earlier.
    task automatic model_step();
        bit strb, strb_d, rise;
        if (!nrst) begin
            model_clear();
            return;
        end
        strb   = pin_hist[SYNC-1];
        strb_d = pin_hist[SYNC];
        rise   = strb && !strb_d;
        for (int i = 7; i > 0; i--) pin_hist[i] = pin_hist[i-1];
        pin_hist[0] = load_strobe;
        m_pulse = 0;
        if (interface_state == I_IDLE) begin
            m_held = 0; m_latched = 0; m_ovr = 0;
        end else if (m_held) begin
            if (rise) m_ovr = 1;
            if (cipher_ready) begin
                m_pulse = 1; m_held = 0; m_latched = 1;
            end
        end else if (m_latched) begin
            if (!strb) m_latched = 0;
        end else if (rise) begin
            m_data = data_in;
            m_held = 1;
        end
    endtask

    function automatic logic [7:0] m_state();
        return m_held ? 8'd1 : (m_latched ? 8'd2 : 8'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (data_out_pulse) pulse_cnt++;
`ifndef INPUT_HOLDER_DEBOUNCE_EN
        check("model_data", data_out, m_data);
        check("model_pulse", {7'd0, data_out_pulse}, {7'd0, m_pulse});
        check("model_state", {6'd0, input_holder_state_out}, m_state());
        check("model_ovr", {7'd0, overrun}, {7'd0, m_ovr});
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_clear();
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_pulse", {7'd0, data_out_pulse}, 8'd0);
        check("rst_state", {6'd0, input_holder_state_out}, 8'd0);
        check("rst_ovr", {7'd0, overrun}, 8'd0);
        tick();
        nrst = 1'b1;
    endtask

    initial begin
        int lat;
        int hold_len;
        int spins;
        nrst            = 1'b0;
        data_in         = 8'h00;
        load_strobe     = 1'b0;
        interface_state = I_ACTIVE;
        cipher_ready    = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();
        ticks(3);

`ifndef INPUT_HOLDER_DEBOUNCE_EN
        // Held strobe with ready cipher: one byte, minimum latency.
        data_in = 8'hA5; cipher_ready = 1'b1; load_strobe = 1'b1;
        pulse_cnt = 0; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (data_out_pulse && lat == 0) lat = i;
        end
        check("a5_latency", 8'(lat), 8'(SYNC + 2));
        load_strobe = 1'b0;
        ticks(SYNC + 3);
        check("a5_pulses", 8'(pulse_cnt), 8'd1);
        check("a5_data", data_out, 8'hA5);
        check("a5_state", {6'd0, input_holder_state_out}, 8'd0);

        // Cipher stalls for 20 cycles before accepting.
        data_in = 8'h3C; cipher_ready = 1'b0; load_strobe = 1'b1;
        spins = 0;
        while (input_holder_state_out != H_PENDING && spins < 50) begin
            tick(); spins++;
        end
        check("3c_reach_pending", {6'd0, input_holder_state_out}, 8'd1);
        pulse_cnt = 0;
        load_strobe = 1'b0;
        ticks(20);
        check("3c_no_pulse", 8'(pulse_cnt), 8'd0);
        cipher_ready = 1'b1;
        ticks(4);
        check("3c_pulses", 8'(pulse_cnt), 8'd1);
        check("3c_data", data_out, 8'h3C);

        // Second strobe edge while pending sets overrun without overwriting.
        cipher_ready = 1'b0; data_in = 8'h11; load_strobe = 1'b1;
        ticks(SYNC + 2);
        check("ovr_pending", {6'd0, input_holder_state_out}, 8'd1);
        load_strobe = 1'b0;
        ticks(SYNC + 2);
        data_in = 8'h22; load_strobe = 1'b1;
        ticks(SYNC + 3);
        check("ovr_set", {7'd0, overrun}, 8'd1);
        check("ovr_data_kept", data_out, 8'h11);
        interface_state = I_IDLE;
        tick();
        interface_state = I_ACTIVE;
        check("ovr_cleared", {7'd0, overrun}, 8'd0);
        check("ovr_idle_state", {6'd0, input_holder_state_out}, 8'd0);
        load_strobe = 1'b0;
        ticks(SYNC + 2);

        // I_IDLE wins over cipher_ready in the same cycle.
        data_in = 8'h77; load_strobe = 1'b1;
        ticks(SYNC + 2);
        load_strobe = 1'b0;
        pulse_cnt = 0;
        interface_state = I_IDLE; cipher_ready = 1'b1;
        tick();
        interface_state = I_ACTIVE;
        ticks(3);
        check("idle_no_pulse", 8'(pulse_cnt), 8'd0);
        check("idle_state", {6'd0, input_holder_state_out}, 8'd0);
        check("idle_data_kept", data_out, 8'h77);

        // Reset drops a pending byte.
        cipher_ready = 1'b0; data_in = 8'hFF; load_strobe = 1'b1;
        ticks(SYNC + 2);
        check("ff_pending", {6'd0, input_holder_state_out}, 8'd1);
        load_strobe = 1'b0;
        @(negedge clk);
        do_reset();
        pulse_cnt = 0;
        cipher_ready = 1'b1;
        ticks(10);
        check("ff_no_pulse", 8'(pulse_cnt), 8'd0);
        check("ff_data", data_out, 8'h00);

        // Random traffic against the model.
        hold_len = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold_len == 0) begin
                if (!load_strobe) data_in = 8'($urandom);
                load_strobe = ~load_strobe;
                hold_len = $urandom_range(1, 8);
            end
            hold_len--;
            cipher_ready    = ($urandom_range(0, 2) != 0);
            interface_state = ($urandom_range(0, 19) == 0) ? I_IDLE : I_ACTIVE;
            tick();
        end
`else
        // Debounced build: a short glitch is ignored, a long enough level is taken.
        data_in = 8'h5A; cipher_ready = 1'b0; load_strobe = 1'b1;
        ticks(3);
        load_strobe = 1'b0;
        ticks(15);
        check("deb_glitch_state", {6'd0, input_holder_state_out}, 8'd0);
        check("deb_glitch_data", data_out, 8'h00);
        load_strobe = 1'b1;
        ticks(4);
        load_strobe = 1'b0;
        ticks(15);
        check("deb_capture_state", {6'd0, input_holder_state_out}, 8'd1);
        check("deb_capture_data", data_out, 8'h5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
